// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the instruction-fetch port, the data (LOAD/STORE) port and the
// shared single-ported memory port of mem_arbiter.
//   fetch : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//   data  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_ack, d_rdata
//   error : addr_err (pulses with the response of a bad access)
//   memory: mem_addr, mem_we, mem_wdata -> mem_rdata (combinational read)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (both requesters plus the memory array)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int DEPTH_LOG2 = 6
);
    logic                  if_req;
    logic [31:0]           if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [31:0]           if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [31:0]           d_addr;
    logic [31:0]           d_wdata;
    logic                  d_gnt;
    logic                  d_ack;
    logic [31:0]           d_rdata;

    logic                  addr_err;

    logic [DEPTH_LOG2-1:0] mem_addr;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_ack, d_rdata,
               addr_err, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_ack, d_rdata,
               addr_err, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported, combinationally read memory between an
// instruction-fetch port and a data port. Data wins contention unless fetch
// has already lost STARVE_LIMIT times in a row. Every access completes one
// cycle after its grant (if_rvalid / d_ack). Misaligned or out-of-range
// addresses are still granted but never write and read back as zero, with
// addr_err flagged alongside the response.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous reset, active-high
//   bus  - mem_arbiter_if.slave: fetch port, data port, memory port
// Parameters:
//   DEPTH_LOG2   - log2 of memory depth in 32-bit words
//   STARVE_LIMIT - consecutive data grants allowed while fetch waits
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DEPTH_LOG2   = 6,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RESP_IF = 2'd1;
    localparam logic [1:0] ST_RESP_D  = 2'd2;

    // Counter wide enough to hold STARVE_LIMIT itself (at least one bit).
    localparam int              CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_starve_cnt;
    logic                  r_addr_err;
    logic [31:0]           r_if_rdata;
    logic [31:0]           r_d_rdata;

    logic                  w_if_gnt;
    logic                  w_d_gnt;
    logic                  w_if_bad;
    logic                  w_d_bad;
    logic                  w_grant_bad;
    logic [DEPTH_LOG2-1:0] w_mem_addr;
    logic [31:0]           w_rdata;
    logic [1:0]            w_next_state;

    // A word address is usable only when aligned and inside the memory.
    assign w_if_bad = (bus.if_addr[1:0] != 2'b00) || (bus.if_addr[31:DEPTH_LOG2+2] != '0);
    assign w_d_bad  = (bus.d_addr[1:0]  != 2'b00) || (bus.d_addr[31:DEPTH_LOG2+2]  != '0);

    // Grant selection. Reset blocks both grants so nothing reaches memory.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a missed branch would infer a latch.
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (!rst) begin
            if (bus.if_req && bus.d_req) begin
                if (r_starve_cnt == LIMIT) begin
                    w_if_gnt = 1'b1;
                end else begin
                    w_d_gnt = 1'b1;
                end
            end else begin
                w_if_gnt = bus.if_req;
                w_d_gnt  = bus.d_req;
            end
        end
    end

    // Memory port steering: idle cycles present address 0 with no write.
    always_comb begin
        w_mem_addr = '0;
        if (w_if_gnt) begin
            w_mem_addr = bus.if_addr[DEPTH_LOG2+1:2];
        end else if (w_d_gnt) begin
            w_mem_addr = bus.d_addr[DEPTH_LOG2+1:2];
        end
    end

    assign w_grant_bad = (w_if_gnt && w_if_bad) || (w_d_gnt && w_d_bad);
    assign w_rdata     = w_grant_bad ? 32'h0 : bus.mem_rdata;

    always_comb begin
        w_next_state = ST_IDLE;
        if (w_if_gnt) begin
            w_next_state = ST_RESP_IF;
        end else if (w_d_gnt) begin
            w_next_state = ST_RESP_D;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= '0;
            r_addr_err   <= 1'b0;
            r_if_rdata   <= 32'h0;
            r_d_rdata    <= 32'h0;
        end else begin
            r_state    <= w_next_state;
            r_addr_err <= w_grant_bad;

            // Counts data wins that kept a waiting fetch out; any fetch
            // grant or fetch idle cycle restarts the count.
            if (!bus.if_req || w_if_gnt) begin
                r_starve_cnt <= '0;
            end else if (w_d_gnt && (r_starve_cnt != LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            if (w_if_gnt) begin
                r_if_rdata <= w_rdata;
            end
            // A STORE leaves the last LOAD result in place.
            if (w_d_gnt && !bus.d_we) begin
                r_d_rdata <= w_rdata;
            end
        end
    end

    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_we    = w_d_gnt && bus.d_we && !w_d_bad;
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.if_rvalid = (r_state == ST_RESP_IF);
    assign bus.d_ack     = (r_state == ST_RESP_D);
    assign bus.addr_err  = r_addr_err;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 6: log2 of the shared memory depth in 32-bit words.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 3: maximum number of consecutive data grants while fetch waits.
REQ-003 The block SHALL run on one clock; reset is synchronous and active-high. The ports are:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  instruction-fetch request
if_addr  in  32  fetch byte address (pc)
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  if_rdata valid
if_rdata  out  32  fetched instruction
d_req  in  1  data (LOAD/STORE) request
d_we  in  1  1 = STORE, 0 = LOAD
d_addr  in  32  data byte address
d_wdata  in  32  STORE data
d_gnt  out  1  data request accepted this cycle
d_ack  out  1  data access complete (LOAD or STORE)
d_rdata  out  32  LOAD result
addr_err  out  1  completing access had a bad address
mem_addr  out  DEPTH_LOG2  word index to shared memory
mem_we  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_rdata  in  32  combinational memory read data at mem_addr

Function
REQ-004 The block SHALL assert at most one of if_gnt/d_gnt per cycle; the grants SHALL be combinational from the requests and the current state.
REQ-005 The data port SHALL win when both ports request, except when starve_cnt == STARVE_LIMIT, in which case the fetch port SHALL win.
REQ-006 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on a d_gnt cycle while if_req=1, and SHALL clear on any if_gnt cycle or any cycle with if_req=0.
REQ-007 In the grant cycle, mem_addr SHALL equal the winner's addr[DEPTH_LOG2+1:2], and mem_we SHALL equal d_gnt & d_we & ~bad.
REQ-008 mem_wdata SHALL equal d_wdata at all times.
REQ-009 In a cycle with no grant, mem_addr SHALL be 0 and mem_we SHALL be 0.
REQ-010 An address SHALL be bad when addr[1:0] != 0 or addr[31:DEPTH_LOG2+2] != 0. A bad access SHALL still be granted, SHALL never write, and SHALL return read data 0.
REQ-011 The response FSM SHALL have states IDLE, RESP_IF and RESP_D. Next state SHALL be RESP_IF on if_gnt, RESP_D on d_gnt, and IDLE otherwise.
REQ-012 Latency SHALL be 1 cycle. In RESP_IF, if_rvalid=1 and if_rdata holds mem_rdata registered at the grant edge. In RESP_D, d_ack=1; on a LOAD, d_rdata holds the registered mem_rdata; on a STORE, d_rdata is unchanged.
REQ-013 The STORE SHALL take effect at the grant-cycle rising edge, and a fetch or LOAD of the same word in the next cycle SHALL see the new value.
REQ-014 addr_err SHALL pulse for one cycle together with the if_rvalid/d_ack of the bad access.
REQ-015 Requesters SHALL hold req, addr, we and wdata stable until gnt. A new request MAY be presented in the cycle after gnt, giving a throughput of one access per cycle.
REQ-016 if_rdata and d_rdata SHALL hold their last values when not valid.

Reset
REQ-017 On rst=1 at a rising edge, the following SHALL clear: state to IDLE, starve_cnt to 0, if_rvalid, d_ack and addr_err to 0, and if_rdata and d_rdata to 0.
REQ-018 While rst=1, if_gnt, d_gnt and mem_we SHALL be 0.
REQ-019 A response pending when rst asserts SHALL be dropped, with no valid/ack after reset.

Verification
REQ-020 Fetch only: if_req=1, if_addr=0x08, memory word 2 = 0xDEADBEEF. Response: if_gnt in cycle N; if_rvalid=1 and if_rdata=0xDEADBEEF in N+1.
REQ-021 STORE then LOAD: STORE 0x12345678 to 0x3C, then LOAD 0x3C. Response: mem_we=1 only in the STORE grant cycle with mem_addr=15; d_ack in each following cycle; d_rdata=0x12345678.
REQ-022 Starvation: if_req and d_req held high continuously with STARVE_LIMIT=3. Response: grant pattern D,D,D,IF repeating; if_gnt no later than the 4th cycle.
REQ-023 Bad addresses: STORE to 0x41 and LOAD from 0x100. Response: both granted; mem_we=0; d_rdata=0 for the LOAD; addr_err=1 with each d_ack; memory unchanged.
REQ-024 Reset mid-operation: rst=1 in the cycle after a d_gnt LOAD. Response: d_ack=0 and d_rdata=0 in the following cycle; no grants while rst=1; normal fetch resumes after rst drops.
